// File: rtl/hv_job_sched_if.sv
// Control bundle between the register file, the output-stream sink and hv_job_sched.
// slave is the scheduler's view; master is the driver's view.
interface hv_job_sched_if #(
  parameter int DEPTH = 4,
  parameter int IW    = 16,
  parameter int AW    = 20,
  parameter int CW    = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          job_push;
  logic          job_gen;
  logic [IW-1:0] job_items;
  logic [AW-1:0] job_words;
  logic [AW-1:0] job_ngram;
  logic          job_full;
  logic [LW-1:0] job_level;
  logic          abort;
  logic          clear_err;
  logic          dst_valid;
  logic          dst_ready;
  logic          dst_last;
  logic [AW-1:0] cfg_addr_i;
  logic [AW-1:0] cfg_addr_j;
  logic [IW-1:0] cfg_random_num;
  logic          matw;
  logic [IW-1:0] mat_a;
  logic          run;
  logic          busy;
  logic          done_pulse;
  logic [CW-1:0] jobs_done;
  logic          err_overflow;

  modport slave (
    input  job_push, job_gen, job_items, job_words, job_ngram,
    input  abort, clear_err, dst_valid, dst_ready, dst_last,
    output job_full, job_level, cfg_addr_i, cfg_addr_j, cfg_random_num,
    output matw, mat_a, run, busy, done_pulse, jobs_done, err_overflow
  );

  modport master (
    output job_push, job_gen, job_items, job_words, job_ngram,
    output abort, clear_err, dst_valid, dst_ready, dst_last,
    input  job_full, job_level, cfg_addr_i, cfg_addr_j, cfg_random_num,
    input  matw, mat_a, run, busy, done_pulse, jobs_done, err_overflow
  );
endinterface

// File: rtl/hv_job_sched.sv
// HDC encode job scheduler: queues job descriptors, optionally sweeps the item memory
// (matw/mat_a), then holds run until the final output-stream beat of the job.
module hv_job_sched #(
  parameter int DEPTH = 4,
  parameter int IW    = 16,
  parameter int AW    = 20,
  parameter int CW    = 16
) (
  input  logic           AXIS_ACLK,
  input  logic           AXIS_ARESETN,
  hv_job_sched_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, GEN, GAP, RUN, DONE} state_t;

  typedef struct packed {
    logic          gen;
    logic [IW-1:0] items;
    logic [AW-1:0] words;
    logic [AW-1:0] ngram;
  } job_t;

  job_t          queue_mem [DEPTH];
  job_t          head;
  job_t          wr_entry;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop;
  logic          err_reg;

  state_t        state;
  logic          cfg_gen;
  logic [AW-1:0] cfg_addr_i;
  logic [AW-1:0] cfg_addr_j;
  logic [IW-1:0] cfg_random_num;
  logic          matw;
  logic [IW-1:0] mat_a;
  logic          run;
  logic          done_pulse;
  logic [CW-1:0] jobs_done;
  logic          stream_end;

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  // A full queue drops the push even when the scheduler pops in the same cycle.
  assign push_ok    = bus.job_push && !full;
  assign pop        = (state == IDLE) && !empty;
  assign head       = queue_mem[rd_ptr];
  assign stream_end = bus.dst_valid && bus.dst_ready && bus.dst_last;

  assign wr_entry.gen   = bus.job_gen;
  assign wr_entry.items = bus.job_items;
  assign wr_entry.words = bus.job_words;
  assign wr_entry.ngram = bus.job_ngram;

  // Descriptor storage carries no reset; only the pointers define validity.
  always_ff @(posedge AXIS_ACLK) begin
    if (push_ok) begin
      queue_mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      err_reg <= 1'b0;
    end else if (bus.job_push && full) begin
      err_reg <= 1'b1;
    end else if (bus.clear_err) begin
      err_reg <= 1'b0;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state          <= IDLE;
      cfg_gen        <= 1'b0;
      cfg_addr_i     <= '0;
      cfg_addr_j     <= '0;
      cfg_random_num <= '0;
      matw           <= 1'b0;
      mat_a          <= '0;
      run            <= 1'b0;
      done_pulse     <= 1'b0;
      jobs_done      <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state          <= LOAD;
            cfg_gen        <= head.gen;
            cfg_addr_i     <= head.words;
            cfg_addr_j     <= head.ngram;
            cfg_random_num <= head.items;
          end
        end
        LOAD: begin
          if (cfg_gen) begin
            state <= GEN;
            matw  <= 1'b1;
            mat_a <= '0;
          end else begin
            state <= GAP;
          end
        end
        GEN: begin
          if (bus.abort || (mat_a == cfg_random_num)) begin
            state <= bus.abort ? IDLE : GAP;
            matw  <= 1'b0;
            mat_a <= '0;
          end else begin
            mat_a <= mat_a + IW'(1);
          end
        end
        GAP: begin
          // The low run cycle here lets the downstream rst=~run separate jobs.
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
            run   <= 1'b0;
          end else if (stream_end) begin
            state      <= DONE;
            run        <= 1'b0;
            done_pulse <= 1'b1;
            jobs_done  <= jobs_done + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          matw  <= 1'b0;
          run   <= 1'b0;
          mat_a <= '0;
        end
      endcase
    end
  end

  assign bus.job_full       = full;
  assign bus.job_level      = level;
  assign bus.err_overflow   = err_reg;
  assign bus.cfg_addr_i     = cfg_addr_i;
  assign bus.cfg_addr_j     = cfg_addr_j;
  assign bus.cfg_random_num = cfg_random_num;
  assign bus.matw           = matw;
  assign bus.mat_a          = mat_a;
  assign bus.run            = run;
  assign bus.busy           = (state != IDLE);
  assign bus.done_pulse     = done_pulse;
  assign bus.jobs_done      = jobs_done;

endmodule

// File: tb/tb_hv_job_sched.sv
// Directed bench for hv_job_sched: generation sweep, back-to-back jobs, overflow,
// abort, stalled last beat and asynchronous reset during RUN.
module tb_hv_job_sched;
  localparam int DEPTH = 4;
  localparam int IW    = 16;
  localparam int AW    = 20;
  localparam int CW    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hv_job_sched_if #(.DEPTH(DEPTH), .IW(IW), .AW(AW), .CW(CW)) bus ();

  hv_job_sched #(.DEPTH(DEPTH), .IW(IW), .AW(AW), .CW(CW)) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .bus          (bus)
  );

  int checks   = 0;
  int failures = 0;

  int   n, pulses, matw_n, first_run, first_matw, gap_cnt, min_gap;
  logic seq_ok, addr_ok, run_seen, overlap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic g, input int items, input int words, input int ngram);
    bus.job_gen   = g;
    bus.job_items = IW'(items);
    bus.job_words = AW'(words);
    bus.job_ngram = AW'(ngram);
    bus.job_push  = 1'b1;
    $display("push gen=%0d items=%0d words=%0d ngram=%0d", g, items, words, ngram);
    tick();
    bus.job_push = 1'b0;
  endtask

  task automatic set_dst(input logic v, input logic r, input logic l);
    bus.dst_valid = v;
    bus.dst_ready = r;
    bus.dst_last  = l;
  endtask

  initial begin
    bus.job_push = 1'b0; bus.job_gen = 1'b0; bus.job_items = '0;
    bus.job_words = '0; bus.job_ngram = '0; bus.abort = 1'b0; bus.clear_err = 1'b0;
    set_dst(1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_run_matw", {bus.run, bus.matw, bus.done_pulse}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_level", bus.job_level, 0);
    check("rst_jobs_done", bus.jobs_done, 0);
    check("rst_cfg", bus.cfg_addr_i | AW'(bus.cfg_random_num), 0);

    // Generation job: items=99, TLAST on 5th beat
    push_job(1'b1, 99, 7, 2);
    tick();
    check("load_busy", bus.busy, 1);
    check("load_cfg_i", bus.cfg_addr_i, 7);
    check("load_cfg_j", bus.cfg_addr_j, 2);
    check("load_cfg_rn", bus.cfg_random_num, 99);
    tick();
    n = 0; seq_ok = 1'b1;
    for (int c = 0; c < 300 && bus.matw; c++) begin
      if (bus.mat_a !== IW'(n) || bus.run) seq_ok = 1'b0;
      n++;
      tick();
    end
    check("gen_writes", n, 100);
    check("gen_seq", seq_ok, 1);
    check("gap_run", bus.run, 0);
    check("gap_mat_a", bus.mat_a, 0);
    tick();
    check("run_high", bus.run, 1);
    set_dst(1'b1, 1'b1, 1'b0);
    for (int b = 0; b < 4; b++) begin
      tick();
      check("run_beat", bus.run, 1);
    end
    bus.dst_last = 1'b1;
    tick();
    check("done_run_low", bus.run, 0);
    check("done_pulse", bus.done_pulse, 1);
    check("done_count1", bus.jobs_done, 1);
    check("done_cfg_hold", bus.cfg_random_num, 99);
    set_dst(1'b0, 1'b0, 1'b0);
    tick();
    check("done_pulse_single", bus.done_pulse, 0);
    check("idle_busy", bus.busy, 0);

    // Back-to-back: gen=0 then items=0 gen=1
    set_dst(1'b1, 1'b1, 1'b1);
    push_job(1'b0, 5, 3, 1);
    push_job(1'b1, 0, 4, 2);
    matw_n = 0; pulses = 0; first_run = -1; first_matw = -1;
    addr_ok = 1'b1; run_seen = 1'b0; gap_cnt = 0; min_gap = 1000; overlap = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.matw) begin
        matw_n++;
        if (bus.mat_a !== '0) addr_ok = 1'b0;
        if (first_matw < 0) first_matw = c;
      end
      if (bus.matw && bus.run) overlap = 1'b1;
      if (bus.run && first_run < 0) first_run = c;
      if (bus.done_pulse) pulses++;
      if (bus.run) begin
        if (run_seen && gap_cnt > 0 && gap_cnt < min_gap) min_gap = gap_cnt;
        run_seen = 1'b1;
        gap_cnt = 0;
      end else if (run_seen) begin
        gap_cnt++;
      end
      tick();
    end
    set_dst(1'b0, 1'b0, 1'b0);
    check("b2b_matw_cycles", matw_n, 1);
    check("b2b_matw_addr0", addr_ok, 1);
    check("b2b_nogen_first", (first_run >= 0) && (first_run < first_matw), 1);
    check("b2b_run_gap", (min_gap >= 3) && (min_gap != 1000), 1);
    check("b2b_no_overlap", overlap, 0);
    check("b2b_pulses", pulses, 2);
    check("b2b_jobs_done", bus.jobs_done, 3);

    // Overflow with DEPTH=4
    push_job(1'b0, 1, 1, 1);
    tick();
    check("ovf_popped", bus.job_level, 0);
    for (int j = 0; j < 4; j++) push_job(1'b0, j, j + 1, 1);
    check("ovf_full", bus.job_full, 1);
    check("ovf_level4", bus.job_level, 4);
    check("ovf_err_clean", bus.err_overflow, 0);
    push_job(1'b0, 9, 9, 9);
    check("ovf_err_set", bus.err_overflow, 1);
    check("ovf_level_keep", bus.job_level, 4);
    bus.clear_err = 1'b1;
    push_job(1'b0, 9, 9, 9);
    bus.clear_err = 1'b0;
    check("ovf_clear_vs_push", bus.err_overflow, 1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    check("ovf_cleared", bus.err_overflow, 0);
    set_dst(1'b1, 1'b1, 1'b1);
    pulses = 0;
    for (int c = 0; c < 200 && bus.jobs_done != 16'd8; c++) begin
      tick();
      if (bus.done_pulse) pulses++;
    end
    set_dst(1'b0, 1'b0, 1'b0);
    check("ovf_jobs_done", bus.jobs_done, 8);
    check("ovf_pulses", pulses, 5);
    tick();
    check("ovf_drained", bus.job_level, 0);
    check("ovf_idle", bus.busy, 0);

    // Abort at mat_a==10 with a second job queued
    push_job(1'b1, 99, 11, 3);
    push_job(1'b0, 3, 5, 1);
    tick();
    for (int c = 0; c < 50 && bus.mat_a != 16'd10; c++) tick();
    check("abort_at10", bus.mat_a, 10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_matw", bus.matw, 0);
    check("abort_mat_a", bus.mat_a, 0);
    check("abort_idle", bus.busy, 0);
    check("abort_no_pulse", bus.done_pulse, 0);
    check("abort_count", bus.jobs_done, 8);
    tick();
    check("abort_next_load", bus.busy, 1);
    check("abort_next_cfg", bus.cfg_random_num, 3);
    tick();
    check("abort_next_nogen", bus.matw, 0);
    tick();
    check("abort_next_run", bus.run, 1);

    // Stalled last beat
    set_dst(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_run", {bus.run, bus.done_pulse}, 2'b10);
    end
    bus.dst_ready = 1'b1;
    tick();
    set_dst(1'b0, 1'b0, 1'b0);
    check("stall_done", {bus.run, bus.done_pulse}, 2'b01);
    check("stall_count", bus.jobs_done, 9);
    tick();

    // Asynchronous reset during RUN
    push_job(1'b0, 2, 2, 2);
    push_job(1'b0, 3, 3, 3);
    tick();
    tick();
    check("arst_pre_run", bus.run, 1);
    check("arst_pre_level", bus.job_level, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_run", bus.run, 0);
    check("arst_matw_busy", {bus.matw, bus.busy}, 0);
    check("arst_level", bus.job_level, 0);
    check("arst_jobs_done", bus.jobs_done, 0);
    check("arst_cfg", bus.cfg_addr_i, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_after_idle", bus.busy, 0);
    check("arst_after_empty", bus.job_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
